// File: rtl/int_dispatch_queue_pkg.sv
// Shared types and sizing for the integer dispatch queue.
// Also provides the lane-compaction sub-module's reusable definitions.
package int_dispatch_queue_pkg;

    localparam int INTDQ_SIZE     = 16;
    localparam int INTDQ_DISP_WID = 2;
    localparam int INTDQ_PTR_W    = $clog2(INTDQ_SIZE) + 1;

    // MSB of the pointer is the wrap bit; the rest indexes the entry RAM.
    typedef logic [INTDQ_PTR_W-1:0] intdq_ptr_t;

    typedef struct packed {
        logic [7:0]  uop_id;
        logic [5:0]  prd;
        logic [5:0]  prs1;
        logic [5:0]  prs2;
        logic [3:0]  alu_op;
        logic [31:0] imm;
    } intDQEntry_t;

endpackage

// File: rtl/dq_lane_compact.sv
// Turns a per-lane valid mask into compacted write offsets (exclusive prefix
// sum) and the total number of valid lanes.
module dq_lane_compact #(
    parameter int LANES = 4,
    parameter int CNT_W = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0] vld,
    output logic [CNT_W-1:0] offset [LANES],
    output logic [CNT_W-1:0] cnt
);

    // Exclusive prefix count: each lane lands right after the valid lanes below it.
    always_comb begin
        logic [CNT_W-1:0] acc;
        acc    = '0;
        offset = '{default: '0};
        for (int i = 0; i < LANES; i++) begin
            offset[i] = acc;
            if (vld[i]) begin
                acc = acc + CNT_W'(1);
            end else begin
                acc = acc;
            end
        end
        cnt = acc;
    end

endmodule

// File: rtl/int_dispatch_queue_chk.sv
// Runtime properties of the integer dispatch queue: occupancy bound,
// enqueue gating and stall stability of presented entries.
module int_dispatch_queue_chk
    import int_dispatch_queue_pkg::*;
#(
    parameter int DEPTH   = INTDQ_SIZE,
    parameter int DEQ_WID = INTDQ_DISP_WID,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input logic                      clk,
    input logic                      rst,
    input logic [CNT_W-1:0]          count,
    input logic                      can_enq,
    input logic                      enq_fire,
    input logic                      stall,
    input logic                      flush,
    input logic [DEQ_WID-1:0]        deq_vld,
    input intDQEntry_t [DEQ_WID-1:0] deq_info
);

    a_count_bound: assert property (@(posedge clk) disable iff (!rst)
        count <= CNT_W'(DEPTH));

    a_enq_gated: assert property (@(posedge clk) disable iff (!rst)
        enq_fire |-> can_enq);

    for (genvar g = 0; g < DEQ_WID; g++) begin : g_stable
        a_stall_stable: assert property (@(posedge clk) disable iff (!rst)
            (stall && !flush && deq_vld[g]) |=> $stable(deq_info[g]));
    end

endmodule

// File: rtl/int_dispatch_queue.sv
// Integer dispatch queue: circular FIFO between rename/dispatch and the integer
// execute block, presenting the oldest DEQ_WID entries each cycle.
module int_dispatch_queue
    import int_dispatch_queue_pkg::*;
#(
    parameter  int DEPTH   = INTDQ_SIZE,
    parameter  int ENQ_WID = 4,
    parameter  int DEQ_WID = INTDQ_DISP_WID,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    output logic               o_can_enq,
    input  logic [ENQ_WID-1:0] i_enq_vld,
    input  intDQEntry_t        i_enq_info [ENQ_WID],
    input  logic               i_exe_stall,
    output logic [DEQ_WID-1:0] o_deq_vld,
    output intDQEntry_t        o_deq_info [DEQ_WID],
    output logic [CNT_W-1:0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LC_W  = $clog2(ENQ_WID + 1);
    localparam int DQ_W  = $clog2(DEQ_WID + 1);

    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W-1:0] count_s;
    logic [PTR_W:0]   free_s;
    logic             can_enq_s;
    logic             enq_fire_s;
    logic [LC_W-1:0]  enq_off_s [ENQ_WID];
    logic [LC_W-1:0]  enq_n_s;
    logic [DQ_W-1:0]  deq_n_s;
    intDQEntry_t      ram_r [DEPTH];
    intDQEntry_t [DEQ_WID-1:0] deq_info_pk_s;

    // Wrap bit makes tail - head the exact occupancy, including the full case.
    assign count_s    = tail_r - head_r;
    assign free_s     = (PTR_W+1)'(DEPTH) - {1'b0, count_s};
    assign can_enq_s  = free_s >= (PTR_W+1)'(ENQ_WID);
    assign enq_fire_s = can_enq_s && !i_flush;
    assign o_can_enq  = can_enq_s;
    assign o_count    = CNT_W'(count_s);

    dq_lane_compact #(
        .LANES (ENQ_WID),
        .CNT_W (LC_W)
    ) u_lane_compact (
        .vld    (i_enq_vld),
        .offset (enq_off_s),
        .cnt    (enq_n_s)
    );

    // Present the oldest entries straight from registered state; no bypass.
    always_comb begin
        logic [IDX_W-1:0] rd_idx;
        rd_idx     = '0;
        deq_n_s    = '0;
        o_deq_vld  = '0;
        o_deq_info = '{default: '0};
        for (int i = 0; i < DEQ_WID; i++) begin
            rd_idx        = head_r[IDX_W-1:0] + IDX_W'(i);
            o_deq_vld[i]  = count_s > PTR_W'(i);
            o_deq_info[i] = ram_r[rd_idx];
            if (o_deq_vld[i]) begin
                deq_n_s = deq_n_s + DQ_W'(1);
            end else begin
                deq_n_s = deq_n_s;
            end
        end
    end

    // Entry RAM write: compacted valid lanes land at tail, tail+1, ...
    always_ff @(posedge clk) begin
        if (rst && enq_fire_s) begin
            for (int i = 0; i < ENQ_WID; i++) begin
                if (i_enq_vld[i]) begin
                    ram_r[tail_r[IDX_W-1:0] + IDX_W'(enq_off_s[i])] <= i_enq_info[i];
                end
            end
        end
    end

    // Head/tail pointers; reset beats flush, flush discards the cycle's traffic.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_r <= '0;
            tail_r <= '0;
        end else if (i_flush) begin
            head_r <= '0;
            tail_r <= '0;
        end else begin
            if (enq_fire_s) begin
                tail_r <= tail_r + PTR_W'(enq_n_s);
            end
            if (!i_exe_stall) begin
                head_r <= head_r + PTR_W'(deq_n_s);
            end
        end
    end

    for (genvar g = 0; g < DEQ_WID; g++) begin : g_pack
        assign deq_info_pk_s[g] = o_deq_info[g];
    end

    int_dispatch_queue_chk #(
        .DEPTH   (DEPTH),
        .DEQ_WID (DEQ_WID),
        .CNT_W   (CNT_W)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .count    (o_count),
        .can_enq  (can_enq_s),
        .enq_fire (enq_fire_s),
        .stall    (i_exe_stall),
        .flush    (i_flush),
        .deq_vld  (o_deq_vld),
        .deq_info (deq_info_pk_s)
    );

endmodule

// File: tb/tb_int_dispatch_queue.sv
// Directed bench for int_dispatch_queue: reset, fill, compaction, stall across
// wrap, simultaneous enqueue/dequeue and flush/reset priority.
module tb_int_dispatch_queue;
    import int_dispatch_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_flush;
    logic        o_can_enq;
    logic [3:0]  i_enq_vld;
    intDQEntry_t i_enq_info [4];
    logic        i_exe_stall;
    logic [1:0]  o_deq_vld;
    intDQEntry_t o_deq_info [2];
    logic [4:0]  o_count;

    int n_checks = 0;
    int n_errors = 0;

    int_dispatch_queue dut (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (i_flush),
        .o_can_enq   (o_can_enq),
        .i_enq_vld   (i_enq_vld),
        .i_enq_info  (i_enq_info),
        .i_exe_stall (i_exe_stall),
        .o_deq_vld   (o_deq_vld),
        .o_deq_info  (o_deq_info),
        .o_count     (o_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_enq(input logic [3:0] mask, input logic [7:0] base);
        i_enq_vld = mask;
        for (int l = 0; l < 4; l++) begin
            i_enq_info[l]        = '0;
            i_enq_info[l].uop_id = base + 8'(l);
        end
    endtask

    task automatic check_state(input string tag, input logic [1:0] vld,
                               input logic [4:0] cnt, input logic can);
        check_val({tag, "_vld"}, 32'(o_deq_vld), 32'(vld));
        check_val({tag, "_cnt"}, 32'(o_count), 32'(cnt));
        check_val({tag, "_can"}, 32'(o_can_enq), 32'(can));
    endtask

    task automatic check_info(input string tag, input logic [7:0] id0, input logic [7:0] id1);
        check_val({tag, "_id0"}, 32'(o_deq_info[0].uop_id), 32'(id0));
        check_val({tag, "_id1"}, 32'(o_deq_info[1].uop_id), 32'(id1));
    endtask

    initial begin
        rst         = 1'b0;
        i_flush     = 1'b0;
        i_exe_stall = 1'b0;
        set_enq(4'b0000, 8'h00);

        // reset, then idle
        step();
        step();
        rst = 1'b1;
        check_state("reset", 2'b00, 5'd0, 1'b1);
        step();
        step();
        check_state("idle", 2'b00, 5'd0, 1'b1);

        // fill to full while stalled
        i_exe_stall = 1'b1;
        set_enq(4'b1111, 8'h20); step(); check_state("fill4", 2'b11, 5'd4, 1'b1);
        set_enq(4'b1111, 8'h24); step(); check_state("fill8", 2'b11, 5'd8, 1'b1);
        set_enq(4'b1111, 8'h28); step(); check_state("fill12", 2'b11, 5'd12, 1'b1);
        set_enq(4'b1111, 8'h2C); step(); check_state("fill16", 2'b11, 5'd16, 1'b0);
        set_enq(4'b1111, 8'h90); step(); check_state("full_hold", 2'b11, 5'd16, 1'b0);
        check_info("full_hold", 8'h20, 8'h21);

        // reset mid-fill with an enqueue pending
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_state("rst_mid", 2'b00, 5'd0, 1'b1);

        // sparse mask compaction
        set_enq(4'b1010, 8'hA0); step();
        set_enq(4'b0000, 8'h00);
        check_state("sparse", 2'b11, 5'd2, 1'b1);
        check_info("sparse", 8'hA1, 8'hA3);

        rst = 1'b0;
        step();
        rst = 1'b1;

        // fill to 12, then enqueue 4 and dequeue 2 together
        set_enq(4'b1111, 8'h20); step();
        set_enq(4'b1111, 8'h24); step();
        set_enq(4'b1111, 8'h28); step();
        check_state("pre_sim", 2'b11, 5'd12, 1'b1);
        check_info("pre_sim", 8'h20, 8'h21);
        i_exe_stall = 1'b0;
        set_enq(4'b1111, 8'h2C); step();
        check_state("sim", 2'b11, 5'd14, 1'b0);
        check_info("sim", 8'h22, 8'h23);

        // drain until head sits at index 14
        set_enq(4'b0000, 8'h00);
        for (int k = 0; k < 6; k++) step();
        check_state("drain", 2'b11, 5'd2, 1'b1);
        check_info("drain", 8'h2E, 8'h2F);

        // queue two more across the wrap, then stall three cycles
        i_exe_stall = 1'b1;
        set_enq(4'b0011, 8'h40); step();
        set_enq(4'b0000, 8'h00);
        check_state("wrap_enq", 2'b11, 5'd4, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check_info("stall", 8'h2E, 8'h2F);
        end
        i_exe_stall = 1'b0;
        step();
        check_state("wrap_deq1", 2'b11, 5'd2, 1'b1);
        check_info("wrap_deq1", 8'h40, 8'h41);
        step();
        check_state("wrap_deq2", 2'b00, 5'd0, 1'b1);

        // flush priority over enqueue and dequeue at count 6
        i_exe_stall = 1'b1;
        set_enq(4'b1111, 8'h50); step();
        set_enq(4'b0011, 8'h54); step();
        check_state("pre_flush", 2'b11, 5'd6, 1'b1);
        i_flush     = 1'b1;
        i_exe_stall = 1'b0;
        set_enq(4'b1111, 8'h60); step();
        check_state("flush", 2'b00, 5'd0, 1'b1);
        i_flush     = 1'b0;
        i_exe_stall = 1'b1;
        set_enq(4'b0001, 8'h77); step();
        set_enq(4'b0000, 8'h00);
        check_state("post_flush", 2'b01, 5'd1, 1'b1);
        check_val("post_flush_id0", 32'(o_deq_info[0].uop_id), 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/int_dispatch_queue.md
Name: int_dispatch_queue

Overview:
Integer dispatch queue (intDQ). It sits between rename/dispatch and the integer execute block, which it feeds directly. It buffers renamed integer micro-ops in a circular FIFO and presents up to INTDQ_DISP_WID oldest entries per cycle to the execute block. It honours the execute block's stall and a global pipeline flush.

Parameters:
DEPTH, 16, number of entries; must be a power of 2 and at least ENQ_WID + DEQ_WID.
ENQ_WID, 4, enqueue lanes per cycle from dispatch.
DEQ_WID, `INTDQ_DISP_WID, dequeue lanes per cycle to the execute block.

Ports:
clk  input  1  single clock; all state updates on posedge.
rst  input  1  synchronous, active-low reset; sampled on posedge clk.
i_flush  input  1  pipeline flush (mispredict or exception); empties the queue.
o_can_enq  output  1  queue can accept a full ENQ_WID group this cycle.
i_enq_vld  input  ENQ_WID  per-lane enqueue valid; any bit pattern is legal.
i_enq_info  input  intDQEntry_t[ENQ_WID]  per-lane entry payload.
i_exe_stall  input  1  stall from the execute block (its o_intBlock_stall).
o_deq_vld  output  DEQ_WID  per-lane dequeue valid to the execute block.
o_deq_info  output  intDQEntry_t[DEQ_WID]  oldest entries; lane 0 is the oldest.
o_count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage and pointers:
  - Entry RAM plus head/tail pointers, each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - count = tail - head, modulo 2^(ptr width).
  - Full when the index bits are equal and the wrap bits differ. Empty when the pointers are fully equal.
- Reset (rst==0 at posedge): head=tail=0.
  - Outputs afterwards: o_count=0, o_deq_vld=0, o_can_enq=1.
  - RAM payload is not reset.
  - Reset overrides flush, enqueue and dequeue in the same cycle.
- o_can_enq is combinational from registered count: (DEPTH - count) >= ENQ_WID. It is all-or-nothing per cycle.
- Enqueue:
  - Fires when o_can_enq && !i_flush. Valid lanes are compacted in lane order (prefix-sum of i_enq_vld) into tail, tail+1, ...
  - tail += popcount(i_enq_vld); index wraps modulo DEPTH and the wrap bit toggles.
  - When o_can_enq==0, i_enq_vld is ignored (producer must hold). No entry is dropped or partially written.
- Dequeue presentation is combinational from registered state: o_deq_vld[i] = (count > i); o_deq_info[i] = ram[head+i].
  - An entry written at cycle t is visible on o_deq_* no earlier than t+1. There is no enqueue-to-dequeue bypass.
- Dequeue handshake:
  - When i_exe_stall==0 and !i_flush, all presented valid lanes are consumed: head += popcount(o_deq_vld).
  - When i_exe_stall==1, head holds and o_deq_* stay stable (same entries, same order).
- Simultaneous enqueue and dequeue in one cycle is legal.
  - o_can_enq uses the pre-dequeue count; freed slots become usable the next cycle.
  - Next count = count + enq_n - deq_n, where 0 <= count <= DEPTH always.
- Flush: when i_flush==1 at posedge, head=tail=0 and the cycle's enqueue/dequeue are discarded.
  - Next cycle: o_deq_vld=0, o_count=0.
  - o_deq_vld is not masked combinationally during the flush cycle. The execute block qualifies its inputs with flush.
- Wrap-around: entry order is preserved across the DEPTH-1 -> 0 boundary for both pointers; dequeue lanes read ram[(head+i) mod DEPTH].
- Assertions:
  - count never exceeds DEPTH.
  - No enqueue fires while o_can_enq==0.
  - o_deq_info is stable while i_exe_stall==1 and !i_flush.

Decomposition:
- Shared package (core_define): intDQEntry_t, INTDQ_DISP_WID, INTDQ_SIZE (DEPTH default), and the pointer typedef intdq_ptr_t with its wrap bit.
- Natural sub-module: dq_lane_compact. It takes the ENQ_WID valid mask and produces per-lane write offsets plus the popcount, and is reusable by the future memory dispatch queue.
- Everything else stays inline.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then rst=1 -> o_deq_vld=0, o_can_enq=1, o_count=0; all inputs zero keep it so.
- Fill to full: enqueue i_enq_vld=4'b1111 for 3 cycles with i_exe_stall=1 -> o_count 4,8,12. o_can_enq=1 through count=12, then 0 at count=16 after a 4th enqueue; a further enqueue attempt changes nothing.
- Sparse mask compaction: enqueue i_enq_vld=4'b1010 with payload IDs A,B,C,D -> next cycle o_deq_info[0]=B, o_deq_info[1]=D, o_deq_vld=2'b11, o_count=2.
- Stall then drain across wrap: head at index 14, 4 entries queued, i_exe_stall=1 for 3 cycles -> o_deq_info constant. Release the stall -> entries at indices 14,15 leave, then 0,1; head wrap bit toggles and order is preserved.
- Simultaneous enq/deq at count=12: enqueue 4 and dequeue 2 in one cycle -> o_count=14 next cycle, and o_can_enq=0 that next cycle.
- Flush priority: i_flush=1 together with an enqueue of 4 and no stall at count=6 -> next cycle o_count=0, o_deq_vld=0. Also rst=0 with i_flush=0 mid-fill -> identical empty state.
